// File: rtl/vga_pixel_framebuffer_if.sv
// ---------------------------------------------------------------------------
// vga_pixel_framebuffer_if
//
// Pixel-plot bus between the game's drawing datapath (master) and the
// framebuffer (slave).
//
//   x_in        master -> slave  plot column, 0..159
//   y_in        master -> slave  plot row, 0..119
//   colour_in   master -> slave  {R,G,B}
//   plot        master -> slave  write strobe, sampled every clk
//   clear       master -> slave  start a background fill of the whole buffer
//   busy        slave -> master  high while a clear is running
//   frame_start slave -> master  one-clk pulse at the start of each frame
// ---------------------------------------------------------------------------
interface vga_pixel_framebuffer_if;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic       plot;
    logic       clear;
    logic       busy;
    logic       frame_start;

    modport master (
        output x_in, y_in, colour_in, plot, clear,
        input  busy, frame_start
    );

    modport slave (
        input  x_in, y_in, colour_in, plot, clear,
        output busy, frame_start
    );
endinterface

// File: rtl/vga_pixel_framebuffer.sv
// ---------------------------------------------------------------------------
// vga_pixel_framebuffer
//
// 160x120, 3-bit framebuffer written through the pixel-plot bus and scanned
// out continuously as 640x480@60 VGA with 4x pixel replication. A clear
// fills the whole buffer with BG_COLOUR, one word per clk.
//
// Ports:
//   clk          50 MHz system clock
//   reset_n      synchronous, active-low reset
//   bus          pixel-plot bus (slave side): x_in, y_in, colour_in, plot,
//                clear in; busy, frame_start out
//   vga_r/g/b    colour bit replicated to 8 bits, 0 outside the active area
//   vga_hs/vs    active-low syncs
//   vga_blank_n  high during the active region
//   vga_sync_n   tied 0
//   vga_clk      25 MHz pixel clock, registered
// ---------------------------------------------------------------------------
module vga_pixel_framebuffer #(
    parameter int         H_ACTIVE  = 640,
    parameter int         H_FP      = 16,
    parameter int         H_SYNC    = 96,
    parameter int         H_BP      = 48,
    parameter int         V_ACTIVE  = 480,
    parameter int         V_FP      = 10,
    parameter int         V_SYNC    = 2,
    parameter int         V_BP      = 33,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    vga_pixel_framebuffer_if.slave        bus,
    output logic [7:0]                    vga_r,
    output logic [7:0]                    vga_g,
    output logic [7:0]                    vga_b,
    output logic                          vga_hs,
    output logic                          vga_vs,
    output logic                          vga_blank_n,
    output logic                          vga_sync_n,
    output logic                          vga_clk
);

    localparam int          FB_W      = 160;
    localparam int          FB_H      = 120;
    localparam int          FB_DEPTH  = FB_W * FB_H;
    localparam int          H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [14:0] LAST_ADDR = 15'(FB_DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t      state, state_next;
    logic [14:0] clr_addr, clr_addr_next;

    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        plot_in_range;
    logic [14:0] plot_row, plot_col, plot_addr;

    logic        pix_en;
    logic [9:0]  h_cnt, v_cnt;
    logic        h_last, v_last;
    logic        frame_start_r;

    logic        active_raw, hs_raw, vs_raw;
    logic [14:0] rd_row, rd_col, rd_addr;

    logic [2:0]  mem [FB_DEPTH];

    logic [2:0]  rd_data_p1;
    logic        active_p1, hs_p1, vs_p1;

    // -----------------------------------------------------------------------
    // Write port: plot address = y*160 + x, built from shifts.
    // -----------------------------------------------------------------------
    always_comb begin
        plot_row      = 15'(bus.y_in);
        plot_col      = 15'(bus.x_in);
        plot_addr     = (plot_row << 7) + (plot_row << 5) + plot_col;
        plot_in_range = (bus.x_in < 8'(FB_W)) && (bus.y_in < 7'(FB_H));
    end

    // -----------------------------------------------------------------------
    // Clear FSM. Plots and further clears are ignored while CLEAR runs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        wr_en         = 1'b0;
        wr_addr       = plot_addr;
        wr_data       = bus.colour_in;
        case (state)
            IDLE: begin
                wr_en = bus.plot && plot_in_range;
                if (bus.clear) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_addr;
                wr_data = BG_COLOUR;
                if (clr_addr == LAST_ADDR) begin
                    state_next = IDLE;
                end else begin
                    clr_addr_next = clr_addr + 15'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy        = (state == CLEAR);
    assign bus.frame_start = frame_start_r;

    // -----------------------------------------------------------------------
    // Stage p0: pixel enable and scan counters. Each screen pixel spans two
    // clks; the counters step on the second (pix_en=1). vga_clk rises at
    // the start of that second half, i.e. mid-pixel.
    // -----------------------------------------------------------------------
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_en        <= 1'b0;
            vga_clk       <= 1'b0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            frame_start_r <= 1'b0;
        end else begin
            pix_en        <= ~pix_en;
            vga_clk       <= ~pix_en;
            frame_start_r <= pix_en && h_last && v_last;
            if (pix_en) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    always_comb begin
        active_raw = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
        hs_raw     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_raw     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        rd_row     = 15'(v_cnt >> 2);
        rd_col     = 15'(h_cnt >> 2);
        // Outside the active area the row index can exceed the buffer, so
        // park the read on address 0; the data is blanked anyway.
        rd_addr    = active_raw ? (rd_row << 7) + (rd_row << 5) + rd_col : '0;
    end

    // -----------------------------------------------------------------------
    // Stage p1: synchronous memory read. Read and write sit in one block with
    // non-blocking assignments, so a same-address collision returns old data.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && reset_n) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_p1 <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_p1 <= 1'b0;
            hs_p1     <= 1'b1;
            vs_p1     <= 1'b1;
        end else begin
            active_p1 <= active_raw;
            hs_p1     <= hs_raw;
            vs_p1     <= vs_raw;
        end
    end

    // -----------------------------------------------------------------------
    // Stage p2: registered VGA outputs, two clks (one pixel) after the
    // counters, aligned with the read data.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            vga_r       <= active_p1 ? {8{rd_data_p1[2]}} : 8'd0;
            vga_g       <= active_p1 ? {8{rd_data_p1[1]}} : 8'd0;
            vga_b       <= active_p1 ? {8{rd_data_p1[0]}} : 8'd0;
            vga_hs      <= hs_p1;
            vga_vs      <= vs_p1;
            vga_blank_n <= active_p1;
        end
    end

    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_pixel_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_framebuffer
//
// Directed bench for vga_pixel_framebuffer. The DUT is built with a short
// vertical frame and narrow horizontal porches so that full scan-outs fit in
// a short run; the active width stays 640 so column 159 is on screen.
// Frame 0 lines 16..27 and frame 1 lines 0..15 are compared pixel by pixel
// against a hand-set image, so every visible line is covered once.
// ---------------------------------------------------------------------------
module tb_vga_pixel_framebuffer;

    localparam int HA = 640, HFP = 8, HS = 16, HBP = 8;
    localparam int HT = HA + HFP + HS + HBP;        // 672 pixels per line
    localparam int VA = 28, VFP = 1, VS = 2, VBP = 1;
    localparam int VT = VA + VFP + VS + VBP;        // 32 lines per frame
    localparam int LINE_CLKS  = 2 * HT;             // 1344
    localparam int FRAME_CLKS = 2 * HT * VT;        // 43008
    localparam int CNT_LIMIT  = 80000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    vga_pixel_framebuffer_if pif();

    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

    vga_pixel_framebuffer #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .BG_COLOUR(3'b000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (pif),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_blank_n(vga_blank_n),
        .vga_sync_n (vga_sync_n),
        .vga_clk    (vga_clk)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected buffer image after the clear: background plus two plots.
    logic [2:0] model [0:19199];

    // cnt equals the number of clk edges since reset was released.
    int   cnt = 0;
    logic run = 1'b0;
    always @(posedge clk) if (run) cnt <= cnt + 1;

    // ---------------- scan-out monitor ----------------
    logic mon_en = 1'b0, mon_done = 1'b0;
    int   pix_err = 0, sync_err = 0, fs_early = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_blank = 1'b0;
    int   line_start = 0, first_line = -1, second_line = -1, n_lines0 = 0;
    int   blank_len = -1, hs_off = -1, hs_fall = 0, hs_len = -1;
    int   vs_fall = 0, vs_off = -1, vs_len = -1;
    int   m_p, m_h, m_ln, m_v, m_f;
    logic m_even, m_act, m_hs, m_vs, m_region;
    logic [2:0]  m_c;
    logic [23:0] m_rgb, m_exp;

    always @(negedge clk) begin
        if (mon_en && !mon_done && cnt >= 2) begin
            m_p    = (cnt - 2) / 2;
            m_even = ((cnt - 2) % 2) == 0;
            m_h    = m_p % HT;
            m_ln   = m_p / HT;
            m_v    = m_ln % VT;
            m_f    = m_ln / VT;
            m_act  = (m_h < HA) && (m_v < VA);
            m_hs   = !((m_h >= HA + HFP) && (m_h < HA + HFP + HS));
            m_vs   = !((m_v >= VA + VFP) && (m_v < VA + VFP + VS));
            m_rgb  = {vga_r, vga_g, vga_b};

            if (vga_blank_n !== m_act || vga_hs !== m_hs || vga_vs !== m_vs || vga_sync_n !== 1'b0)
                sync_err++;

            m_region = (m_f == 0 && m_v >= 16) || (m_f == 1 && m_v < 16);
            if (m_region && m_act) begin
                m_c   = model[(m_v / 4) * 160 + (m_h / 4)];
                m_exp = {{8{m_c[2]}}, {8{m_c[1]}}, {8{m_c[0]}}};
                if (m_rgb !== m_exp) pix_err++;
            end else if (!m_act && m_rgb !== 24'd0) begin
                pix_err++;
            end

            if (cnt == FRAME_CLKS)          check_val("frame_start_pulse", pif.frame_start, 1);
            else if (cnt == FRAME_CLKS + 1) check_val("frame_start_width", pif.frame_start, 0);
            else if (cnt < FRAME_CLKS && pif.frame_start === 1'b1) fs_early++;

            if (m_even && m_f == 0) begin
                if (m_h == 40  && m_v == 20) check_val("plot_px_40_20",  m_rgb, 24'hFFFF00);
                if (m_h == 43  && m_v == 23) check_val("plot_px_43_23",  m_rgb, 24'hFFFF00);
                if (m_h == 39  && m_v == 20) check_val("plot_px_39_20",  m_rgb, 24'h000000);
                if (m_h == 44  && m_v == 23) check_val("plot_px_44_23",  m_rgb, 24'h000000);
                if (m_h == 636 && m_v == 20) check_val("edge_px_636_20", {vga_blank_n, m_rgb}, {1'b1, 24'h0000FF});
                if (m_h == 639 && m_v == 23) check_val("edge_px_639_23", {vga_blank_n, m_rgb}, {1'b1, 24'h0000FF});
                if (m_h == 640 && m_v == 20) check_val("edge_px_640_20", {vga_blank_n, m_rgb}, 25'd0);
                if (m_h == 0   && m_v == 24) check_val("oor_x_no_wrap",  m_rgb, 24'h000000);
            end
            if (m_even && m_f == 1) begin
                if (m_h == 0  && m_v == 0)  check_val("oor_y_no_wrap",   m_rgb, 24'h000000);
                if (m_h == 12 && m_v == 12) check_val("midclear_plot",   m_rgb, 24'h000000);
            end

            if (m_f == 0) begin
                if (vga_blank_n && !prev_blank) begin
                    if (first_line < 0) first_line = cnt;
                    else if (second_line < 0) second_line = cnt;
                    line_start = cnt;
                    n_lines0++;
                end
                if (!vga_blank_n && prev_blank && blank_len < 0) blank_len = cnt - line_start;
                if (!vga_hs && prev_hs) begin
                    hs_fall = cnt;
                    if (hs_off < 0) hs_off = cnt - line_start;
                end
                if (vga_hs && !prev_hs && hs_len < 0) hs_len = cnt - hs_fall;
                if (!vga_vs && prev_vs) begin
                    vs_fall = cnt;
                    vs_off  = cnt - first_line;
                end
                if (vga_vs && !prev_vs && vs_len < 0) vs_len = cnt - vs_fall;
            end
            prev_hs    = vga_hs;
            prev_vs    = vga_vs;
            prev_blank = vga_blank_n;

            if (m_f == 1 && m_v >= 16) mon_done = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_plot(input int x, input int y, input logic [2:0] c);
        pif.x_in      = 8'(x);
        pif.y_in      = 7'(y);
        pif.colour_in = c;
        pif.plot      = 1'b1;
        @(negedge clk);
    endtask

    int busy_cnt;

    initial begin
        pif.x_in = '0; pif.y_in = '0; pif.colour_in = '0;
        pif.plot = 1'b0; pif.clear = 1'b0;
        for (int i = 0; i < 19200; i++) model[i] = 3'b000;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("rst_hs",          vga_hs, 1);
        check_val("rst_vs",          vga_vs, 1);
        check_val("rst_blank_n",     vga_blank_n, 0);
        check_val("rst_rgb",         {vga_r, vga_g, vga_b}, 0);
        check_val("rst_busy",        pif.busy, 0);
        check_val("rst_frame_start", pif.frame_start, 0);
        check_val("rst_vga_clk",     vga_clk, 0);
        check_val("sync_n_tied",     vga_sync_n, 0);

        reset_n = 1'b1;
        run     = 1'b1;
        mon_en  = 1'b1;

        // Back-to-back 111 plots that the clear must wipe out.
        drive_plot(3, 3, 3'b111);
        drive_plot(0, 0, 3'b111);
        drive_plot(159, 5, 3'b111);
        pif.plot = 1'b0;
        check_val("busy_idle", pif.busy, 0);

        pif.clear = 1'b1;
        @(negedge clk);
        pif.clear = 1'b0;
        check_val("busy_rise", pif.busy, 1);

        // Mid-clear: a plot and a second clear, both must be ignored.
        busy_cnt = 0;
        while (pif.busy === 1'b1 && busy_cnt < 30000) begin
            busy_cnt++;
            if (busy_cnt == 9600) begin
                pif.x_in = 8'd3; pif.y_in = 7'd3; pif.colour_in = 3'b010;
                pif.plot = 1'b1; pif.clear = 1'b1;
            end else if (busy_cnt == 9601) begin
                pif.plot = 1'b0; pif.clear = 1'b0;
            end
            @(negedge clk);
        end
        check_val("busy_len", busy_cnt, 19200);

        drive_plot(10, 5, 3'b110);
        drive_plot(159, 5, 3'b001);
        drive_plot(160, 5, 3'b111);
        drive_plot(0, 120, 3'b111);
        pif.plot = 1'b0;
        model[5 * 160 + 10]  = 3'b110;
        model[5 * 160 + 159] = 3'b001;

        while (!mon_done && cnt < CNT_LIMIT) @(negedge clk);
        check_val("scan_done", mon_done, 1);
        mon_en = 1'b0;

        check_val("pixel_errors",   pix_err, 0);
        check_val("sync_errors",    sync_err, 0);
        check_val("frame_start_early", fs_early, 0);
        check_val("blank_len",      blank_len, 2 * HA);
        check_val("line_period",    second_line - first_line, LINE_CLKS);
        check_val("hs_offset",      hs_off, 2 * (HA + HFP));
        check_val("hs_len",         hs_len, 2 * HS);
        check_val("active_lines",   n_lines0, VA);
        check_val("vs_offset",      vs_off, LINE_CLKS * (VA + VFP));
        check_val("vs_len",         vs_len, LINE_CLKS * VS);

        // Reset during a clear aborts it at once.
        pif.clear = 1'b1;
        @(negedge clk);
        pif.clear = 1'b0;
        repeat (50) @(negedge clk);
        check_val("busy_mid_clear", pif.busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_val("reset_aborts_clear", pif.busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("idle_after_abort", pif.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
